// File: rtl/boss_bullet_pkg.sv
// Shared types and helpers for the boss bullet engine: FSM states, volley
// patterns and the velocity clamp used when a bullet is spawned.
package boss_bullet_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COOLDOWN = 2'd1,
      ST_VOLLEY   = 2'd2
   } state_t;

   typedef enum logic {
      PAT_FAN   = 1'b0,
      PAT_AIMED = 1'b1
   } pattern_t;

   localparam int VEL_W   = 5;
   localparam int VEL_MAX = 7;
   localparam int VEL_MIN = -8;

   function automatic logic signed [VEL_W-1:0] clip_vel(input int v);
      int c;
      if (v > VEL_MAX)      c = VEL_MAX;
      else if (v < VEL_MIN) c = VEL_MIN;
      else                  c = v;
      return c[VEL_W-1:0];
   endfunction

endpackage

// File: rtl/boss_bullet_array_if.sv
// Bundle between boss/player logic, the bullet engine and the renderer.
// No handshake: every field is a level sampled once per clk22 tick.
interface boss_bullet_array_if
   import boss_bullet_pkg::*;
#(
   parameter int N_BULLET = 8,
   parameter int W        = 10
);
   logic                  gamestart;
   logic                  boss;
   logic                  pattern;
   logic [W-1:0]          reimux;
   logic [W-1:0]          reimuy;
   logic [W-1:0]          bossx;
   logic [W-1:0]          bossy;
   logic [N_BULLET-1:0]   bullet_valid;
   logic [N_BULLET*W-1:0] bullet_x;
   logic [N_BULLET*W-1:0] bullet_y;
   logic                  shot;
   logic [7:0]            hit_count;
   state_t                dbg_state;

   modport master (
      output gamestart, boss, pattern, reimux, reimuy, bossx, bossy,
      input  bullet_valid, bullet_x, bullet_y, shot, hit_count, dbg_state
   );

   modport slave (
      input  gamestart, boss, pattern, reimux, reimuy, bossx, bossy,
      output bullet_valid, bullet_x, bullet_y, shot, hit_count, dbg_state
   );
endinterface

// File: rtl/bullet_slot.sv
// One bullet slot: spawn load, hit test against the player hitbox,
// despawn off the top/bottom edge, wall bounce and motion.
module bullet_slot
   import boss_bullet_pkg::*;
#(
   parameter int W      = 10,
   parameter int XMIN   = 30,
   parameter int XMAX   = 410,
   parameter int YMIN   = 8,
   parameter int YMAX   = 472,
   parameter int HIT_HX = 11,
   parameter int HIT_HY = 11
)(
   input  logic                    i_clk,
   input  logic                    i_clr,
   input  logic                    i_spawn,
   input  logic [W-1:0]            i_spawn_x,
   input  logic [W-1:0]            i_spawn_y,
   input  logic signed [VEL_W-1:0] i_spawn_dx,
   input  logic signed [VEL_W-1:0] i_spawn_dy,
   input  logic [W-1:0]            i_px,
   input  logic [W-1:0]            i_py,
   output logic                    o_valid,
   output logic [W-1:0]            o_x,
   output logic [W-1:0]            o_y,
   output logic                    o_hit
);
   localparam logic [W-1:0]        L_XMIN = W'(XMIN);
   localparam logic [W-1:0]        L_XMAX = W'(XMAX);
   localparam logic [W-1:0]        L_YMIN = W'(YMIN);
   localparam logic [W-1:0]        L_YMAX = W'(YMAX);
   localparam logic signed [W:0]   L_HX   = (W+1)'(HIT_HX);
   localparam logic signed [W:0]   L_HY   = (W+1)'(HIT_HY);

   logic                    r_valid;
   logic [W-1:0]            r_x, r_y;
   logic signed [VEL_W-1:0] r_dx, r_dy;
   logic signed [W:0]       w_ddx, w_ddy, w_adx, w_ady;
   logic                    w_hit, w_off, w_bounce;
   logic signed [VEL_W-1:0] w_dx;

   // Differences are one bit wider than coordinates so a player near 0 cannot wrap.
   assign w_ddx = $signed({1'b0, r_x}) - $signed({1'b0, i_px});
   assign w_ddy = $signed({1'b0, r_y}) - $signed({1'b0, i_py});
   assign w_adx = w_ddx[W] ? -w_ddx : w_ddx;
   assign w_ady = w_ddy[W] ? -w_ddy : w_ddy;

   assign w_hit    = r_valid && (w_adx < L_HX) && (w_ady < L_HY);
   assign w_off    = (r_y > L_YMAX) || (r_y < L_YMIN);
   assign w_bounce = ((r_x < L_XMIN) && r_dx[VEL_W-1]) ||
                     ((r_x > L_XMAX) && !r_dx[VEL_W-1] && (r_dx != '0));
   assign w_dx     = w_bounce ? -r_dx : r_dx;

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_valid <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_dx    <= '0;
         r_dy    <= '0;
      end else if (i_spawn) begin
         r_valid <= 1'b1;
         r_x     <= i_spawn_x;
         r_y     <= i_spawn_y;
         r_dx    <= i_spawn_dx;
         r_dy    <= i_spawn_dy;
      end else if (r_valid) begin
         if (w_hit || w_off) begin
            r_valid <= 1'b0;
         end else begin
            r_dx <= w_dx;
            r_x  <= r_x + {{(W-VEL_W){w_dx[VEL_W-1]}}, w_dx};
            r_y  <= r_y + {{(W-VEL_W){r_dy[VEL_W-1]}}, r_dy};
         end
      end
   end

   assign o_valid = r_valid;
   assign o_x     = r_x;
   assign o_y     = r_y;
   assign o_hit   = w_hit;
endmodule

// File: rtl/boss_bullet_array.sv
// Boss bullet engine top: volley FSM, lowest-free-slot spawn select,
// N_BULLET bullet slots, registered shot pulse and saturating hit counter.
module boss_bullet_array
   import boss_bullet_pkg::*;
#(
   parameter int N_BULLET    = 8,
   parameter int W           = 10,
   parameter int FIRE_PERIOD = 16,
   parameter int VOLLEY_LEN  = 8,
   parameter int XMIN        = 30,
   parameter int XMAX        = 410,
   parameter int YMIN        = 8,
   parameter int YMAX        = 472,
   parameter int HIT_HX      = 11,
   parameter int HIT_HY      = 11,
   parameter int SPAWN_DY    = 16
)(
   input logic                clk22,
   input logic                rst,
   boss_bullet_array_if.slave bus
);
   localparam int               CNT_W      = $clog2(FIRE_PERIOD);
   localparam int               K_W        = (VOLLEY_LEN > 1) ? $clog2(VOLLEY_LEN) : 1;
   localparam logic [CNT_W-1:0] L_CNT_LOAD = CNT_W'(FIRE_PERIOD - 1);
   localparam logic [K_W-1:0]   L_K_LAST   = K_W'(VOLLEY_LEN - 1);

   state_t                  r_state, w_state_nxt;
   pattern_t                r_pattern, w_pattern_nxt;
   logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
   logic [K_W-1:0]          r_k, w_k_nxt;
   logic                    w_clr, w_spawn_en;
   logic [N_BULLET-1:0]     w_valid, w_hit, w_free, w_spawn_oh;
   logic [N_BULLET*W-1:0]   w_x, w_y;
   logic signed [W:0]       w_aim_diff, w_aim_sh;
   logic signed [VEL_W-1:0] w_vel_dx, w_vel_dy;
   logic [W-1:0]            w_spawn_y;
   logic                    r_shot;
   logic [7:0]              r_hit_count;

   // Dropping the boss phase wipes the field just like a reset, but keeps the score.
   assign w_clr = rst || bus.gamestart || !bus.boss;

   always_ff @(posedge clk22) begin
      if (w_clr) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_k       <= '0;
         r_pattern <= PAT_FAN;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_k       <= w_k_nxt;
         r_pattern <= w_pattern_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_k_nxt       = r_k;
      w_pattern_nxt = r_pattern;
      case (r_state)
         ST_IDLE: begin
            if (bus.boss) begin
               w_state_nxt = ST_COOLDOWN;
               w_cnt_nxt   = L_CNT_LOAD;
            end
         end
         ST_COOLDOWN: begin
            if (r_cnt == '0) begin
               w_state_nxt   = ST_VOLLEY;
               w_pattern_nxt = pattern_t'(bus.pattern);
               w_k_nxt       = '0;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ST_VOLLEY: begin
            if (r_k == L_K_LAST) begin
               w_state_nxt = ST_COOLDOWN;
               w_cnt_nxt   = L_CNT_LOAD;
            end else begin
               w_k_nxt = r_k + 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_spawn_en = (r_state == ST_VOLLEY);
   end

   // Lowest free slot from registered valids; a slot freed this tick stays busy until next.
   assign w_free     = ~w_valid;
   assign w_spawn_oh = w_spawn_en ? (w_free & (~w_free + N_BULLET'(1))) : '0;

   assign w_aim_diff = $signed({1'b0, bus.reimux}) - $signed({1'b0, bus.bossx});
   assign w_aim_sh   = w_aim_diff >>> 4;
   assign w_vel_dx   = (r_pattern == PAT_AIMED) ? clip_vel(int'(w_aim_sh))
                                                : clip_vel(int'(r_k) - N_BULLET / 2);
   assign w_vel_dy   = (r_pattern == PAT_AIMED) ? 5'sd6 : 5'sd4;
   assign w_spawn_y  = bus.bossy + W'(SPAWN_DY);

   for (genvar g = 0; g < N_BULLET; g++) begin : g_slot
      bullet_slot #(
         .W(W), .XMIN(XMIN), .XMAX(XMAX), .YMIN(YMIN), .YMAX(YMAX),
         .HIT_HX(HIT_HX), .HIT_HY(HIT_HY)
      ) u_slot (
         .i_clk      (clk22),
         .i_clr      (w_clr),
         .i_spawn    (w_spawn_oh[g]),
         .i_spawn_x  (bus.bossx),
         .i_spawn_y  (w_spawn_y),
         .i_spawn_dx (w_vel_dx),
         .i_spawn_dy (w_vel_dy),
         .i_px       (bus.reimux),
         .i_py       (bus.reimuy),
         .o_valid    (w_valid[g]),
         .o_x        (w_x[g*W +: W]),
         .o_y        (w_y[g*W +: W]),
         .o_hit      (w_hit[g])
      );
   end

   always_ff @(posedge clk22) begin
      if (rst || bus.gamestart) begin
         r_shot      <= 1'b0;
         r_hit_count <= '0;
      end else if (!bus.boss) begin
         r_shot <= 1'b0;
      end else begin
         r_shot <= |w_hit;
         if ((|w_hit) && (r_hit_count != 8'hFF)) r_hit_count <= r_hit_count + 8'd1;
      end
   end

   assign bus.bullet_valid = w_valid;
   assign bus.bullet_x     = w_x;
   assign bus.bullet_y     = w_y;
   assign bus.shot         = r_shot;
   assign bus.hit_count    = r_hit_count;
   assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_boss_bullet_array.sv
// Directed bench for boss_bullet_array: cadence, FAN/AIMED trajectories, bounce,
// hit window, underflow edge, full-array drops, clears and hit-count saturation.
module tb_boss_bullet_array;
   import boss_bullet_pkg::*;

   localparam int N = 8;
   localparam int W = 10;

   logic clk22 = 1'b0;
   logic rst   = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [31:0] exp_q[$];

   boss_bullet_array_if #(.N_BULLET(N), .W(W)) bus ();
   boss_bullet_array_if #(.N_BULLET(N), .W(W)) bus2 ();

   boss_bullet_array #(.N_BULLET(N), .W(W)) u_dut (
      .clk22 (clk22),
      .rst   (rst),
      .bus   (bus)
   );

   boss_bullet_array #(.N_BULLET(N), .W(W), .VOLLEY_LEN(12)) u_dut2 (
      .clk22 (clk22),
      .rst   (rst),
      .bus   (bus2)
   );

   assign bus2.gamestart = bus.gamestart;
   assign bus2.boss      = bus.boss;
   assign bus2.pattern   = bus.pattern;
   assign bus2.reimux    = bus.reimux;
   assign bus2.reimuy    = bus.reimuy;
   assign bus2.bossx     = bus.bossx;
   assign bus2.bossy     = bus.bossy;

   // clock / watchdog
   always #5 clk22 = ~clk22;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk22);
      #1;
   endtask

   function automatic logic [31:0] sx(input int i);
      return 32'(bus.bullet_x[i*W +: W]);
   endfunction

   function automatic logic [31:0] sy(input int i);
      return 32'(bus.bullet_y[i*W +: W]);
   endfunction

   function automatic logic [31:0] s2x(input int i);
      return 32'(bus2.bullet_x[i*W +: W]);
   endfunction

   function automatic logic [31:0] s2y(input int i);
      return 32'(bus2.bullet_y[i*W +: W]);
   endfunction

   task automatic set_pos(input int px, input int py, input int bx, input int by);
      bus.reimux = W'(px);
      bus.reimuy = W'(py);
      bus.bossx  = W'(bx);
      bus.bossy  = W'(by);
   endtask

   task automatic clear_boss();
      bus.boss = 1'b0;
      tick();
   endtask

   // Runs until slot 0 is occupied; returns the edge count it took.
   task automatic wait_spawn(input string tag, output int n);
      n = 0;
      while (bus.bullet_valid[0] !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.bullet_valid[0]), 32'd1);
   endtask

   initial begin
      int n;
      int hc;
      logic [31:0] e_y;

      bus.gamestart = 1'b0;
      bus.boss      = 1'b0;
      bus.pattern   = 1'b0;
      set_pos(0, 0, 0, 0);
      tick();
      tick();
      chk("rst_valid", 32'(bus.bullet_valid), 32'd0);
      chk("rst_shot", 32'(bus.shot), 32'd0);
      chk("rst_hc", 32'(bus.hit_count), 32'd0);
      chk("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
      chk("rst_xy", {30'd0, |bus.bullet_x, |bus.bullet_y}, 32'd0);

      // Cadence, FAN trajectory, bounce and full-array drops on the second instance
      rst = 1'b0;
      bus.boss = 1'b1;
      set_pos(50, 400, 220, 40);
      for (int k = 0; k <= 105; k++) exp_q.push_back(32'(56 + 4 * k));
      for (int e = 1; e <= 130; e++) begin
         tick();
         chk("no_shot", 32'(bus.shot), 32'd0);
         if (e <= 17) chk("pre_volley", 32'(bus.bullet_valid), 32'd0);
         if (e == 17) chk("volley_entry", 32'(bus.dbg_state), 32'(ST_VOLLEY));
         if (e >= 18 && e <= 25) chk("fill", 32'(bus.bullet_valid), (32'd1 << (e - 17)) - 32'd1);
         if (e == 18) begin
            chk("spawn_x0", sx(0), 32'd220);
            chk("spawn_y0", sy(0), 32'd56);
         end
         if (e == 25) begin
            chk("volley_exit", 32'(bus.dbg_state), 32'(ST_COOLDOWN));
            bus.reimux = W'(400);
            bus.reimuy = W'(20);
         end
         if (e == 29) begin
            chk("full_state", 32'(bus2.dbg_state), 32'(ST_COOLDOWN));
            chk("full_valid", 32'(bus2.bullet_valid), 32'hFF);
            chk("full_x7", s2x(7), 32'd232);
            chk("full_y7", s2y(7), 32'd72);
            chk("full_x0", s2x(0), 32'd176);
            chk("full_y0", s2y(0), 32'd100);
         end
         if (e == 66) chk("bounce_y0", sy(0), 32'd248);
         if (e >= 66 && e <= 68) chk("bounce_x0", sx(0), 32'(28 + 4 * (e - 66)));
         if (e >= 22 && exp_q.size() != 0) begin
            e_y = exp_q.pop_front();
            chk("fan_y4", sy(4), e_y);
            chk("fan_x4", sx(4), 32'd220);
         end
         if (e == 128) chk("fan_despawn4", 32'(bus.bullet_valid[4]), 32'd0);
      end
      chk("runA_hc", 32'(bus.hit_count), 32'd0);
      hc = 0;

      // Hit window: offset 10 hits, offset 11 does not
      clear_boss();
      set_pos(100, 300, 110, 284);
      bus.boss = 1'b1;
      wait_spawn("spawn_hit10", n);
      set_pos(100, 300, 220, 40);
      tick();
      hc++;
      chk("hit10_shot", 32'(bus.shot), 32'd1);
      chk("hit10_hc", 32'(bus.hit_count), 32'(hc));
      chk("hit10_free", 32'(bus.bullet_valid[0]), 32'd0);
      tick();
      chk("hit10_pulse_end", 32'(bus.shot), 32'd0);

      clear_boss();
      set_pos(100, 300, 111, 284);
      bus.boss = 1'b1;
      wait_spawn("spawn_hit11", n);
      set_pos(100, 300, 220, 40);
      tick();
      chk("hit11_shot", 32'(bus.shot), 32'd0);
      chk("hit11_valid", 32'(bus.bullet_valid[0]), 32'd1);
      chk("hit11_hc", 32'(bus.hit_count), 32'(hc));

      // Player near x=0: no wrap in the distance
      clear_boss();
      set_pos(3, 200, 12, 184);
      bus.boss = 1'b1;
      wait_spawn("spawn_uf12", n);
      set_pos(3, 200, 220, 40);
      tick();
      hc++;
      chk("uf12_shot", 32'(bus.shot), 32'd1);
      chk("uf12_hc", 32'(bus.hit_count), 32'(hc));

      clear_boss();
      set_pos(3, 200, 1020, 184);
      bus.boss = 1'b1;
      wait_spawn("spawn_uf1020", n);
      tick();
      chk("uf1020_shot", 32'(bus.shot), 32'd0);
      chk("uf1020_valid", 32'(bus.bullet_valid[0]), 32'd1);

      // AIMED: dx=(80>>>4)=5 then (-220>>>4)=-14 clipped to -8, dy=6
      clear_boss();
      bus.pattern = 1'b1;
      set_pos(300, 400, 220, 40);
      bus.boss = 1'b1;
      wait_spawn("spawn_aim", n);
      bus.reimux = W'(0);
      tick();
      chk("aim_x0", sx(0), 32'd225);
      chk("aim_y0", sy(0), 32'd62);
      chk("aim_x1_spawn", sx(1), 32'd220);
      tick();
      chk("aim_x1", sx(1), 32'd212);
      chk("aim_y1", sy(1), 32'd62);
      chk("aim_x0_2", sx(0), 32'd230);
      chk("aim_hc", 32'(bus.hit_count), 32'(hc));

      // Clear priority: boss drop mid-volley, then gamestart
      clear_boss();
      bus.pattern = 1'b0;
      set_pos(400, 20, 220, 40);
      bus.boss = 1'b1;
      wait_spawn("spawn_mid", n);
      tick();
      tick();
      chk("mid_state", 32'(bus.dbg_state), 32'(ST_VOLLEY));
      chk("mid_valid", 32'(bus.bullet_valid), 32'd7);
      bus.boss = 1'b0;
      tick();
      chk("drop_valid", 32'(bus.bullet_valid), 32'd0);
      chk("drop_state", 32'(bus.dbg_state), 32'(ST_IDLE));
      chk("drop_hc_held", 32'(bus.hit_count), 32'(hc));
      chk("drop_xy", {30'd0, |bus.bullet_x, |bus.bullet_y}, 32'd0);
      bus.boss      = 1'b1;
      bus.gamestart = 1'b1;
      set_pos(100, 300, 100, 284);
      tick();
      chk("gs_hc", 32'(bus.hit_count), 32'd0);
      chk("gs_state", 32'(bus.dbg_state), 32'(ST_IDLE));
      bus.gamestart = 1'b0;

      // Restart latency and hit-count saturation (every spawn lands on the player)
      wait_spawn("spawn_sat", n);
      chk("restart_lat", 32'(n), 32'd18);
      for (int i = 0; i < 8; i++) tick();
      chk("sat_first_volley", 32'(bus.hit_count), 32'd8);
      chk("sat_shot_last", 32'(bus.shot), 32'd1);
      tick();
      chk("sat_shot_gap", 32'(bus.shot), 32'd0);
      for (int i = 0; i < 960; i++) tick();
      chk("sat_hc", 32'(bus.hit_count), 32'd255);

      rst = 1'b1;
      tick();
      chk("rst2_hc", 32'(bus.hit_count), 32'd0);
      chk("rst2_valid", 32'(bus.bullet_valid), 32'd0);
      chk("rst2_state", 32'(bus.dbg_state), 32'(ST_IDLE));
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
